// File: rtl/wb_stage_ctrl.sv
// Writeback stage controller: selects the writeback source, waits for load data,
// extracts and extends the loaded value, and registers the register-file write.
module wb_stage_ctrl #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_regwrite,
    input  logic [RA_W-1:0]               in_rd,
    input  logic [1:0]                    in_wb_sel,
    input  logic [2:0]                    in_funct3,
    input  logic [$clog2(XLEN/8)-1:0]     in_addr_lo,
    input  logic [XLEN-1:0]               in_alu,
    input  logic [XLEN-1:0]               in_pc4,
    input  logic [XLEN-1:0]               in_csr,
    input  logic                          mem_rsp_valid,
    input  logic [XLEN-1:0]               mem_rsp_data,
    output logic                          rf_we,
    output logic [RA_W-1:0]               rf_waddr,
    output logic [XLEN-1:0]               rf_wdata,
    output logic                          misalign_err,
    output logic [CNT_W-1:0]              retired_cnt
);

    localparam int AW = $clog2(XLEN/8);

    typedef enum logic {
        IDLE,
        WAIT_MEM
    } state_t;

    state_t state_q, state_d;

    logic [RA_W-1:0] ld_rd_q;
    logic            ld_rw_q;
    logic [2:0]      ld_f3_q;
    logic [AW-1:0]   ld_alo_q;

    logic            accept;
    logic            latch_en;
    logic            cmp;
    logic            cmp_rw;
    logic            cmp_mis;
    logic [RA_W-1:0] cmp_rd;
    logic [XLEN-1:0] cmp_data;

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_data;
    logic            load_mis;

    // Load extraction works on the word shifted down to the addressed byte lane.
    always_comb begin
        shifted   = mem_rsp_data >> {ld_alo_q, 3'b000};
        load_data = mem_rsp_data;
        load_mis  = 1'b0;
        case (ld_f3_q)
            3'b000: load_data = XLEN'($signed(shifted[7:0]));
            3'b100: load_data = XLEN'(shifted[7:0]);
            3'b001: begin
                load_data = XLEN'($signed(shifted[15:0]));
                load_mis  = ld_alo_q[0];
            end
            3'b101: begin
                load_data = XLEN'(shifted[15:0]);
                load_mis  = ld_alo_q[0];
            end
            3'b010: begin
                load_data = XLEN'($signed(shifted[31:0]));
                load_mis  = (ld_alo_q[1:0] != 2'b00);
            end
            3'b110: begin
                if (XLEN == 64) begin
                    load_data = XLEN'(shifted[31:0]);
                    load_mis  = (ld_alo_q[1:0] != 2'b00);
                end
            end
            3'b011: begin
                if (XLEN == 64) begin
                    load_mis = (ld_alo_q != '0);
                end
            end
            default: load_data = mem_rsp_data;
        endcase
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        in_ready = (state_q == IDLE) && !flush && !rst;
        accept   = in_valid && in_ready;
        state_d  = state_q;
        latch_en = 1'b0;
        cmp      = 1'b0;
        cmp_rw   = in_regwrite;
        cmp_rd   = in_rd;
        cmp_mis  = 1'b0;
        case (in_wb_sel)
            2'd2:    cmp_data = in_pc4;
            2'd3:    cmp_data = in_csr;
            default: cmp_data = in_alu;
        endcase

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_wb_sel == 2'd1) begin
                        latch_en = 1'b1;
                        state_d  = WAIT_MEM;
                    end else begin
                        cmp = 1'b1;
                    end
                end
            end
            WAIT_MEM: begin
                // A flush drops the load even when the response arrives in the same cycle.
                if (flush) begin
                    state_d = IDLE;
                end else if (mem_rsp_valid) begin
                    cmp      = 1'b1;
                    cmp_rw   = ld_rw_q;
                    cmp_rd   = ld_rd_q;
                    cmp_data = load_data;
                    cmp_mis  = load_mis;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            misalign_err <= 1'b0;
            retired_cnt  <= '0;
        end else begin
            state_q      <= state_d;
            rf_we        <= cmp && cmp_rw && (cmp_rd != '0) && !cmp_mis;
            misalign_err <= cmp && cmp_mis;
            if (cmp) begin
                rf_waddr    <= cmp_rd;
                rf_wdata    <= cmp_data;
                retired_cnt <= retired_cnt + CNT_W'(1);
            end
        end
    end

    // NOTE: the latched load fields are only read in WAIT_MEM, which is always
    // entered through a latch, so they carry no reset.
    always_ff @(posedge clk) begin
        if (latch_en) begin
            ld_rd_q  <= in_rd;
            ld_rw_q  <= in_regwrite;
            ld_f3_q  <= in_funct3;
            ld_alo_q <= in_addr_lo;
        end
    end

endmodule

// File: tb/tb_wb_stage_ctrl.sv
// Drives a 32-bit and a 64-bit (CNT_W=4) instance with identical stimulus and
// scoreboards both against a byte-level reference model of writeback and loads.
module tb_wb_stage_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, in_regwrite, mem_rsp_valid;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_funct3, in_addr_lo;
    logic [63:0] in_alu, in_pc4, in_csr, mem_rsp_data;

    logic        a_ready, a_we, a_mis;
    logic [4:0]  a_waddr;
    logic [31:0] a_wdata, a_cnt;
    logic        b_ready, b_we, b_mis;
    logic [4:0]  b_waddr;
    logic [63:0] b_wdata;
    logic [3:0]  b_cnt;

    wb_stage_ctrl #(.XLEN(32), .RA_W(5), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_ready),
        .in_regwrite(in_regwrite), .in_rd(in_rd), .in_wb_sel(in_wb_sel),
        .in_funct3(in_funct3), .in_addr_lo(in_addr_lo[1:0]), .in_alu(in_alu[31:0]),
        .in_pc4(in_pc4[31:0]), .in_csr(in_csr[31:0]), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data[31:0]), .rf_we(a_we), .rf_waddr(a_waddr),
        .rf_wdata(a_wdata), .misalign_err(a_mis), .retired_cnt(a_cnt)
    );

    wb_stage_ctrl #(.XLEN(64), .RA_W(5), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_ready),
        .in_regwrite(in_regwrite), .in_rd(in_rd), .in_wb_sel(in_wb_sel),
        .in_funct3(in_funct3), .in_addr_lo(in_addr_lo), .in_alu(in_alu),
        .in_pc4(in_pc4), .in_csr(in_csr), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data), .rf_we(b_we), .rf_waddr(b_waddr),
        .rf_wdata(b_wdata), .misalign_err(b_mis), .retired_cnt(b_cnt)
    );

    typedef struct packed {
        logic        valid, flush, rw;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [2:0]  f3, alo;
        logic [63:0] alu, pc4, csr;
        logic        rspv;
        logic [63:0] rspd;
    } stim_t;

    typedef struct {
        bit          we;
        bit          mis;
        logic [4:0]  wa;
        logic [63:0] wd;
    } exp_t;

    exp_t  q0[$];
    exp_t  q1[$];
    int    tests = 0;
    int    fails = 0;
    int    comp_cnt = 0;
    bit    mon_en = 0;
    bit    pend = 0;
    stim_t pent;
    logic [63:0] prev_cnt [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic stim_t idle_stim();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // Reference load: access size and signedness follow from funct3, the value is
    // cut out of the word by plain arithmetic on byte offsets.
    function automatic void ref_load(input int xlen, input logic [2:0] f3, input logic [2:0] alo,
                                     input logic [63:0] data, output logic [63:0] val,
                                     output bit mis);
        int          nbytes = 1 << f3[1:0];
        bit          sgn    = !f3[2];
        bit          legal;
        int          off    = (xlen == 32) ? int'(alo) % 4 : int'(alo);
        logic [63:0] w      = (xlen == 32) ? {32'b0, data[31:0]} : data;
        logic [63:0] sh, m;
        legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ||
                (xlen == 64 && (f3 inside {3'd3, 3'd6}));
        if (!legal) begin
            val = w;
            mis = 0;
            return;
        end
        mis = (off % nbytes) != 0;
        sh  = w >> (off * 8);
        if (nbytes < 8) begin
            m  = (64'd1 << (nbytes * 8)) - 64'd1;
            sh = sh & m;
            if (sgn && sh[nbytes*8-1]) sh = sh | ~m;
        end
        val = (xlen == 32) ? (sh & 64'hFFFF_FFFF) : sh;
    endfunction

    task automatic push(input logic rw, input logic [4:0] rd, input logic [63:0] v32,
                        input logic [63:0] v64, input bit m32, input bit m64);
        q0.push_back('{we: rw && rd != 0 && !m32, mis: m32, wa: rd, wd: v32});
        q1.push_back('{we: rw && rd != 0 && !m64, mis: m64, wa: rd, wd: v64});
        comp_cnt++;
    endtask

    task automatic drive(input stim_t s);
        in_valid      = s.valid;
        flush         = s.flush;
        in_regwrite   = s.rw;
        in_rd         = s.rd;
        in_wb_sel     = s.sel;
        in_funct3     = s.f3;
        in_addr_lo    = s.alo;
        in_alu        = s.alu;
        in_pc4        = s.pc4;
        in_csr        = s.csr;
        mem_rsp_valid = s.rspv;
        mem_rsp_data  = s.rspd;
    endtask

    // One clock cycle: drive, check readiness, and advance the reference model.
    task automatic step(input stim_t s);
        logic [63:0] v, v32, v64;
        bit          m32, m64;
        @(posedge clk);
        #1;
        drive(s);
        #1;
        check("in_ready_x32", a_ready, !pend && !s.flush);
        check("in_ready_x64", b_ready, !pend && !s.flush);
        if (pend) begin
            if (s.flush) begin
                pend = 0;
            end else if (s.rspv) begin
                ref_load(32, pent.f3, pent.alo, s.rspd, v32, m32);
                ref_load(64, pent.f3, pent.alo, s.rspd, v64, m64);
                push(pent.rw, pent.rd, v32, v64, m32, m64);
                pend = 0;
            end
        end else if (s.valid && !s.flush) begin
            if (s.sel == 2'd1) begin
                pend = 1;
                pent = s;
            end else begin
                v = (s.sel == 2'd0) ? s.alu : (s.sel == 2'd2) ? s.pc4 : s.csr;
                push(s.rw, s.rd, v & 64'hFFFF_FFFF, v, 0, 0);
            end
        end
    endtask

    task automatic settle();
        step(idle_stim());
        @(negedge clk);
        #1;
    endtask

    task automatic reset_tail();
        @(negedge clk);
        check("rst_we_x32", a_we, 0);
        check("rst_waddr_x32", a_waddr, 0);
        check("rst_wdata_x32", a_wdata, 0);
        check("rst_mis_x32", a_mis, 0);
        check("rst_cnt_x32", a_cnt, 0);
        check("rst_we_x64", b_we, 0);
        check("rst_wdata_x64", b_wdata, 0);
        check("rst_cnt_x64", b_cnt, 0);
        #1;
        mon_en = 1;
    endtask

    task automatic do_reset();
        stim_t s;
        settle();
        check("queue_drained_x32", q0.size(), 0);
        check("queue_drained_x64", q1.size(), 0);
        mon_en = 0;
        @(posedge clk);
        #1;
        s = idle_stim();
        s.valid = 1; s.rw = 1; s.rd = 5'd5; s.alu = 64'h55;
        drive(s);
        rst = 1;
        #1;
        check("ready_in_reset_x32", a_ready, 0);
        check("ready_in_reset_x64", b_ready, 0);
        @(posedge clk);
        #1;
        rst = 0;
        drive(idle_stim());
        pend = 0;
        comp_cnt = 0;
        reset_tail();
    endtask

    task automatic mon_side(input int sd, input logic we, input logic mis, input logic [4:0] wa,
                            input logic [63:0] wd, input logic [63:0] cnt,
                            input logic [63:0] cmask);
        exp_t  e;
        string tag = (sd == 0) ? "x32" : "x64";
        if (!mon_en) begin
            prev_cnt[sd] = cnt;
            return;
        end
        if (cnt !== prev_cnt[sd]) begin
            if ((sd == 0 && q0.size() == 0) || (sd == 1 && q1.size() == 0)) begin
                tests++;
                fails++;
                $display("FAIL unexpected_completion_%s: retired_cnt 0x%0h, none expected", tag, cnt);
            end else begin
                e = (sd == 0) ? q0.pop_front() : q1.pop_front();
                check({"cnt_inc_", tag}, cnt, (prev_cnt[sd] + 64'd1) & cmask);
                check({"rf_we_", tag}, we, e.we);
                check({"misalign_", tag}, mis, e.mis);
                if (e.we) begin
                    check({"rf_waddr_", tag}, wa, e.wa);
                    check({"rf_wdata_", tag}, wd, e.wd);
                end
            end
        end else begin
            check({"quiet_we_mis_", tag}, {we, mis}, 0);
        end
        prev_cnt[sd] = cnt;
    endtask

    always @(negedge clk) begin
        mon_side(0, a_we, a_mis, a_waddr, {32'b0, a_wdata}, {32'b0, a_cnt}, 64'hFFFF_FFFF);
        mon_side(1, b_we, b_mis, b_waddr, b_wdata, {60'b0, b_cnt}, 64'hF);
    end

    initial begin
        stim_t s;
        rst = 1;
        drive(idle_stim());
        repeat (2) @(posedge clk);
        #1;
        check("ready_at_start_x32", a_ready, 0);
        @(posedge clk);
        #1;
        rst = 0;
        reset_tail();

        // Back-to-back ALU writes.
        s = idle_stim(); s.valid = 1; s.rw = 1; s.rd = 5'd3; s.alu = 64'h11;
        step(s);
        s.rd = 5'd4; s.alu = 64'h22;
        step(s);
        settle();
        check("alu_pair_cnt", a_cnt, 2);

        // Signed byte load, response three cycles after accept.
        s = idle_stim(); s.valid = 1; s.rw = 1; s.rd = 5'd7; s.sel = 2'd1; s.f3 = 3'b000; s.alo = 3'd2;
        step(s);
        s = idle_stim(); s.rspd = 64'h0000_0000_0080_0000;
        step(s);
        step(s);
        s.rspv = 1;
        step(s);
        settle();
        check("lb_wdata_x32", a_wdata, 64'hFFFF_FF80);
        check("lb_wdata_x64", b_wdata, 64'hFFFF_FFFF_FFFF_FF80);

        // Misaligned halfword load.
        s = idle_stim(); s.valid = 1; s.rw = 1; s.rd = 5'd8; s.sel = 2'd1; s.f3 = 3'b101; s.alo = 3'd1;
        step(s);
        s = idle_stim(); s.rspv = 1; s.rspd = 64'h1234_5678_9ABC_DEF0;
        step(s);
        settle();
        check("lhu_mis_pulse", a_mis, 1);
        check("lhu_mis_cnt", a_cnt, 4);

        // PC+4 to x0 is retired but not written.
        s = idle_stim(); s.valid = 1; s.rw = 1; s.rd = 5'd0; s.sel = 2'd2; s.pc4 = 64'h104;
        step(s);
        settle();
        check("x0_we", a_we, 0);
        check("x0_cnt", a_cnt, 5);

        // Flush and response together drop the load.
        s = idle_stim(); s.valid = 1; s.rw = 1; s.rd = 5'd9; s.sel = 2'd1; s.f3 = 3'b010;
        step(s);
        s = idle_stim(); s.flush = 1; s.rspv = 1; s.rspd = 64'hDEAD_BEEF;
        step(s);
        settle();
        check("flush_cnt", a_cnt, 5);

        // Reset while a load is outstanding.
        s = idle_stim(); s.valid = 1; s.rw = 1; s.rd = 5'd11; s.sel = 2'd1; s.f3 = 3'b000;
        step(s);
        do_reset();
        step(idle_stim());

        // 64-bit unsigned word load, then wrap the 4-bit counter.
        s = idle_stim(); s.valid = 1; s.rw = 1; s.rd = 5'd10; s.sel = 2'd1; s.f3 = 3'b110; s.alo = 3'd4;
        step(s);
        s = idle_stim(); s.rspv = 1; s.rspd = 64'h8000_0001_1234_5678;
        step(s);
        settle();
        check("lwu_wdata_x64", b_wdata, 64'h0000_0000_8000_0001);
        check("lwu_wdata_x32", a_wdata, 64'h1234_5678);
        for (int i = 0; i < 15; i++) begin
            s = idle_stim(); s.valid = 1; s.rw = 1; s.rd = 5'(i + 1); s.alu = 64'(i);
            step(s);
        end
        settle();
        check("wrap_cnt_x64", b_cnt, 0);
        check("wrap_cnt_x32", a_cnt, 16);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            s       = idle_stim();
            s.valid = $urandom_range(0, 9) < 7;
            s.flush = $urandom_range(0, 9) == 0;
            s.rw    = $urandom_range(0, 3) != 0;
            s.rd    = 5'($urandom_range(0, 31));
            s.sel   = 2'($urandom_range(0, 3));
            s.f3    = 3'($urandom_range(0, 7));
            s.alo   = 3'($urandom_range(0, 7));
            s.alu   = {$urandom, $urandom};
            s.pc4   = {$urandom, $urandom};
            s.csr   = {$urandom, $urandom};
            s.rspv  = $urandom_range(0, 9) < 4;
            s.rspd  = {$urandom, $urandom};
            step(s);
        end
        settle();
        check("final_queue_x32", q0.size(), 0);
        check("final_queue_x64", q1.size(), 0);
        check("final_cnt_x32", a_cnt, 32'(comp_cnt));
        check("final_cnt_x64", b_cnt, 4'(comp_cnt));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
